// File: rtl/aes_mix_columns_iter.sv
// Iterative AES MixColumns/InvMixColumns engine: one column per cycle through a
// single shared column mixer, with valid/ready handshakes on both sides.

// Combinational mix of one 32-bit column; byte r of col_i is row r.
module aes_mix_single_column (
    input  logic        op_i,
    input  logic [31:0] col_i,
    output logic [31:0] col_c
);

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] x2, x4, x8;

    // Row r output uses the column rotated so that a0 is row r
    always_comb begin
        col_c = '0;
        a0 = '0; a1 = '0; a2 = '0; a3 = '0;
        x2 = '0; x4 = '0; x8 = '0;
        for (int r = 0; r < 4; r++) begin
            a0 = col_i[r*8 +: 8];
            a1 = col_i[((r+1)%4)*8 +: 8];
            a2 = col_i[((r+2)%4)*8 +: 8];
            a3 = col_i[((r+3)%4)*8 +: 8];
            if (!op_i) begin
                col_c[r*8 +: 8] = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
            end else begin
                // 14*a0 ^ 11*a1 ^ 13*a2 ^ 9*a3 built from xtime chains
                x2 = xt(a0); x4 = xt(x2); x8 = xt(x4);
                col_c[r*8 +: 8] = x8 ^ x4 ^ x2;
                x2 = xt(a1); x4 = xt(x2); x8 = xt(x4);
                col_c[r*8 +: 8] = col_c[r*8 +: 8] ^ x8 ^ x2 ^ a1;
                x2 = xt(a2); x4 = xt(x2); x8 = xt(x4);
                col_c[r*8 +: 8] = col_c[r*8 +: 8] ^ x8 ^ x4 ^ a2;
                x2 = xt(a3); x4 = xt(x2); x8 = xt(x4);
                col_c[r*8 +: 8] = col_c[r*8 +: 8] ^ x8 ^ a3;
            end
        end
    end

endmodule

module aes_mix_columns_iter (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         op_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] state_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] state_o,
    output logic         busy_o
);

    localparam int unsigned STATE_W = 128;
    localparam int unsigned COL_W   = 32;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_e;

    fsm_e               fsm_q, fsm_d;
    logic [STATE_W-1:0] data_q, data_d;
    logic [STATE_W-1:0] res_q, res_d;
    logic               op_q, op_d;
    logic [1:0]         col_q, col_d;
    logic [COL_W-1:0]   col_sel_c;
    logic [COL_W-1:0]   mixed_c;

    // Gather column col_q out of the latched state
    always_comb begin
        col_sel_c = '0;
        for (int c = 0; c < 4; c++) begin
            if (col_q == 2'(c)) begin
                for (int r = 0; r < 4; r++) begin
                    col_sel_c[r*8 +: 8] = data_q[((r*4)+c)*8 +: 8];
                end
            end
        end
    end

    aes_mix_single_column u_mix (
        .op_i  (op_q),
        .col_i (col_sel_c),
        .col_c (mixed_c)
    );

    // State register; reset wipes every register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q  <= IDLE;
            data_q <= '0;
            res_q  <= '0;
            op_q   <= 1'b0;
            col_q  <= 2'd0;
        end else begin
            fsm_q  <= fsm_d;
            data_q <= data_d;
            res_q  <= res_d;
            op_q   <= op_d;
            col_q  <= col_d;
        end
    end

    // Next-state: accept, walk four columns, hold result until taken; clear wins
    always_comb begin
        fsm_d  = fsm_q;
        data_d = data_q;
        res_d  = res_q;
        op_d   = op_q;
        col_d  = col_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid_i) begin
                    data_d = state_i;
                    op_d   = op_i;
                    col_d  = 2'd0;
                    fsm_d  = BUSY;
                end
            end
            BUSY: begin
                for (int c = 0; c < 4; c++) begin
                    if (col_q == 2'(c)) begin
                        for (int r = 0; r < 4; r++) begin
                            res_d[((r*4)+c)*8 +: 8] = mixed_c[r*8 +: 8];
                        end
                    end
                end
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
        if (clear_i) begin
            fsm_d  = IDLE;
            data_d = '0;
            res_d  = '0;
            op_d   = 1'b0;
            col_d  = 2'd0;
        end
    end

    // Handshake flags decode the state register only
    assign in_ready_o  = (fsm_q == IDLE);
    assign out_valid_o = (fsm_q == DONE);
    assign busy_o      = (fsm_q != IDLE);
    assign state_o     = res_q;

endmodule

// File: tb/tb_aes_mix_columns_iter.sv
// Self-checking bench for aes_mix_columns_iter against a GF(2^8) matrix model.
module tb_aes_mix_columns_iter;

    logic         clk_i = 1'b0;
    logic         rst_i, clear_i, op_i, in_valid_i, out_ready_i;
    logic [127:0] state_i;
    logic         in_ready_o, out_valid_o, busy_o;
    logic [127:0] state_o;

    int n_err    = 0;
    int n_checks = 0;

    aes_mix_columns_iter dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .op_i        (op_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .state_i     (state_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .state_o     (state_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Generic GF(2^8) multiply, AES polynomial
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // Circulant matrix times every column of the state
    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] o;
        if (inv) begin
            coef[0] = 8'd14; coef[1] = 8'd11; coef[2] = 8'd13; coef[3] = 8'd9;
        end else begin
            coef[0] = 8'd2;  coef[1] = 8'd3;  coef[2] = 8'd1;  coef[3] = 8'd1;
        end
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(coef[(j - r + 4) % 4], s[((j*4)+c)*8 +: 8]);
                end
                o[((r*4)+c)*8 +: 8] = acc;
            end
        end
        return o;
    endfunction

    // Columns given as {row3,row2,row1,row0}
    function automatic logic [127:0] pack(input logic [31:0] c0, input logic [31:0] c1,
                                          input logic [31:0] c2, input logic [31:0] c3);
        logic [31:0]  cc [4];
        logic [127:0] s;
        cc[0] = c0; cc[1] = c1; cc[2] = c2; cc[3] = c3;
        s = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[((r*4)+c)*8 +: 8] = cc[c][r*8 +: 8];
        return s;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present a state while IDLE; returns just after the accept edge
    task automatic start(input logic op, input logic [127:0] s);
        op_i = op; state_i = s; in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
    endtask

    // Count edges until out_valid_o, optionally scrambling inputs meanwhile
    task automatic wait_valid(output int lat, input bit scramble);
        lat = 0;
        while (!out_valid_o && lat < 20) begin
            if (scramble) begin
                op_i = ~op_i;
                state_i = {$urandom, $urandom, $urandom, $urandom};
            end
            step();
            lat++;
        end
    endtask

    task automatic txn(input string tag, input logic op, input logic [127:0] s,
                       input logic [127:0] exp, input bit scramble);
        int lat;
        start(op, s);
        wait_valid(lat, scramble);
        check({tag, "_lat"}, 128'(lat), 128'd4);
        check({tag, "_res"}, state_o, exp);
        out_ready_i = 1'b1;
        step();
        check({tag, "_idle"}, {126'd0, out_valid_o, in_ready_o}, 128'b01);
    endtask

    logic [127:0] v_in, v_fwd, v_mix, v_mix_exp, v_other, held, r_s, r_e;
    logic         r_op;
    int           lat, cnt, bad;

    initial begin
        rst_i = 1'b1; clear_i = 1'b0; op_i = 1'b0; in_valid_i = 1'b0;
        out_ready_i = 1'b1; state_i = '0;
        step(); step();
        check("rst_flags", {125'd0, in_ready_o, out_valid_o, busy_o}, 128'b100);
        check("rst_state", state_o, 128'd0);
        rst_i = 1'b0;

        // FIPS-197 column vector, forward, plus busy and latency
        v_in  = 128'h45454545_53535353_13131313_dbdbdbdb;
        v_fwd = 128'hbcbcbcbc_a1a1a1a1_4d4d4d4d_8e8e8e8e;
        start(1'b0, v_in);
        check("busy_after_accept", {126'd0, busy_o, in_ready_o}, 128'b10);
        wait_valid(lat, 1'b0);
        check("fwd_lat", 128'(lat), 128'd4);
        check("fwd_res", state_o, v_fwd);
        step();
        check("fwd_idle", {126'd0, out_valid_o, in_ready_o}, 128'b01);

        txn("inv_rt", 1'b1, v_fwd, v_in, 1'b0);
        txn("c6_fwd", 1'b0, {16{8'hc6}}, {16{8'hc6}}, 1'b0);
        txn("c6_inv", 1'b1, {16{8'hc6}}, {16{8'hc6}}, 1'b0);

        // Distinct columns at their byte positions
        v_mix     = pack({8'h45,8'h53,8'h13,8'hdb}, {8'h5c,8'h22,8'h0a,8'hf2},
                         32'h01010101,              {8'h4c,8'h31,8'h26,8'h2d});
        v_mix_exp = pack({8'hbc,8'ha1,8'h4d,8'h8e}, {8'h9d,8'h58,8'hdc,8'h9f},
                         32'h01010101,              {8'hf8,8'hbd,8'h7e,8'h4d});
        txn("mixed", 1'b0, v_mix, v_mix_exp, 1'b0);

        // Back-pressure with a competing input held valid
        out_ready_i = 1'b0;
        start(1'b0, v_mix);
        wait_valid(lat, 1'b0);
        check("bp_lat", 128'(lat), 128'd4);
        held = state_o;
        check("bp_res", held, v_mix_exp);
        v_other = 128'h0123456789abcdef_fedcba9876543210;
        in_valid_i = 1'b1; state_i = v_other; op_i = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (state_o !== held || in_ready_o !== 1'b0 || out_valid_o !== 1'b1) bad++;
        end
        check("bp_hold", 128'(bad), 128'd0);
        out_ready_i = 1'b1;
        step();
        check("bp_release", {126'd0, out_valid_o, in_ready_o}, 128'b01);
        step();
        in_valid_i = 1'b0;
        check("bp_new_accept", {127'd0, busy_o}, 128'd1);
        wait_valid(lat, 1'b0);
        check("bp_new_lat", 128'(lat), 128'd4);
        check("bp_new_res", state_o, ref_mix(v_other, 1'b1));
        step();

        // Clear at column 2 with a simultaneous input
        start(1'b0, v_in);
        step(); step();
        clear_i = 1'b1; in_valid_i = 1'b1; state_i = v_other;
        step();
        check("clr_flags", {125'd0, in_ready_o, out_valid_o, busy_o}, 128'b100);
        check("clr_state", state_o, 128'd0);
        clear_i = 1'b0; in_valid_i = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid_o || busy_o) cnt++;
        end
        check("clr_quiet", 128'(cnt), 128'd0);

        // Reset while holding a result in DONE
        out_ready_i = 1'b0;
        start(1'b1, v_fwd);
        wait_valid(lat, 1'b0);
        check("rstd_lat", 128'(lat), 128'd4);
        rst_i = 1'b1;
        step();
        check("rstd_flags", {125'd0, in_ready_o, out_valid_o, busy_o}, 128'b100);
        check("rstd_state", state_o, 128'd0);
        rst_i = 1'b0; out_ready_i = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid_o) cnt++;
        end
        check("rstd_quiet", 128'(cnt), 128'd0);

        // Op/state latched at accept despite scrambled inputs
        txn("latch", 1'b0, v_mix, v_mix_exp, 1'b1);

        // Random states against the model, then inverse round-trip
        for (int k = 0; k < 12; k++) begin
            r_s  = {$urandom, $urandom, $urandom, $urandom};
            r_op = 1'($urandom_range(1, 0));
            r_e  = ref_mix(r_s, r_op);
            txn("rand", r_op, r_s, r_e, (k % 3) == 0);
            txn("rand_rt", ~r_op, r_e, r_s, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
